data_mem_arbiter: RTL

//   Shares the single-port 16-bit data memory between two requesters:

---
 rtl/data_mem_arbiter_if.sv | 48 ++++
 rtl/data_mem_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Requester and data-memory signal bundle for data_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
// Combinational wires only; no storage lives here.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Port 0 (CPU load/store stage)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              done0;

    // Port 1 (loader/debug DMA)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              done1;

    // Shared response
    logic [DATA_W-1:0] rdata;
    logic              err;

    // Data memory pins
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_load;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output done0, done1, rdata, err,
        output mem_addr, mem_wdata, mem_write, mem_load
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  done0, done1, rdata, err,
        input  mem_addr, mem_wdata, mem_write, mem_load
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// Latency: req sampled at edge N, memory strobe in cycle N+1, done pulse in cycle N+2.
// Backpressure: requesters hold req until done; one access in flight, at most 1 per 3 cycles.
module data_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              rr_q;        // port favoured when both request
    logic              win_q;       // id of the port being served
    logic              we_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done0_q;
    logic              done1_q;
    logic              err_q;
    logic              mem_write_q;
    logic              mem_load_q;

    logic              grant_vld;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    // Pick the winner among the live requests and mux its command fields.
    always_comb begin
        grant_vld    = bus.req0 | bus.req1;
        grant_id     = (bus.req0 & bus.req1) ? rr_q : bus.req1;
        sel_we       = grant_id ? bus.we1    : bus.we0;
        sel_addr     = grant_id ? bus.addr1  : bus.addr0;
        sel_wdata    = grant_id ? bus.wdata1 : bus.wdata0;
        sel_in_range = ({1'b0, sel_addr} < DEPTH_W);
    end

    // Access sequencer: latch the winner in IDLE, strobe memory in ACCESS, report in RESP.
    // Strobes and done/err are registered so requester inputs cannot glitch them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_q        <= 1'b0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            in_range_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_load_q  <= 1'b0;
        end else begin
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_load_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        win_q       <= grant_id;
                        we_q        <= sel_we;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        in_range_q  <= sel_in_range;
                        mem_write_q <= sel_we & sel_in_range;
                        mem_load_q  <= ~sel_we & sel_in_range;
                        // Only a contested grant moves the pointer.
                        if (bus.req0 & bus.req1) begin
                            rr_q <= ~grant_id;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!in_range_q) begin
                        rdata_q <= '0;
                    end else if (!we_q) begin
                        rdata_q <= bus.mem_rdata;
                    end
                    done0_q <= ~win_q;
                    done1_q <= win_q;
                    err_q   <= ~in_range_q;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_load  = mem_load_q;

endmodule
